// File: rtl/h_bridge_burst_if.sv
// Bundle of control, configuration and gate-drive signals for the H-bridge burst driver.
// start is a one-cycle request, taken only when the driver is idle and abort is low; busy acts as not-ready.
interface h_bridge_burst_if #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
);
  logic               start;
  logic               abort;
  logic [CNT_W-1:0]   half_period;
  logic [CNT_W-1:0]   dead_time;
  logic [BURST_W-1:0] n_cycles;
  logic               hlh;
  logic               hll;
  logic               hrh;
  logic               hrl;
  logic               txrx;
  logic               busy;
  logic               done;
  logic               err;
  logic               aborted;
  logic [3:0]         state_dbg;

  modport master (
    output start, abort, half_period, dead_time, n_cycles,
    input  hlh, hll, hrh, hrl, txrx, busy, done, err, aborted, state_dbg
  );

  modport slave (
    input  start, abort, half_period, dead_time, n_cycles,
    output hlh, hll, hrh, hrl, txrx, busy, done, err, aborted, state_dbg
  );
endinterface

// File: rtl/h_bridge_burst.sv
// Transducer ping generator: N full-bridge cycles with dead time, optional low-side damping,
// and a T/R envelope. Every output is a register; gate patterns are loaded on state entry.
module h_bridge_burst #(
  parameter int CNT_W       = 16,
  parameter int BURST_W     = 8,
  parameter int DAMP_CYCLES = 32
) (
  input logic             clk,
  input logic             rst,
  h_bridge_burst_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    DEAD_A  = 4'd1,
    DRIVE_A = 4'd2,
    DEAD_B  = 4'd3,
    DRIVE_B = 4'd4,
    DEAD_C  = 4'd5,
    DAMP    = 4'd6,
    DONE    = 4'd7
  } state_t;

  // gate bit order {hlh, hll, hrh, hrl}
  localparam logic [3:0] G_OFF  = 4'b0000;
  localparam logic [3:0] G_A    = 4'b1001;
  localparam logic [3:0] G_B    = 4'b0110;
  localparam logic [3:0] G_DAMP = 4'b0101;

  localparam logic [CNT_W-1:0]   ONE_C     = CNT_W'(1);
  localparam logic [BURST_W-1:0] ONE_B     = BURST_W'(1);
  localparam logic [CNT_W-1:0]   DAMP_LAST = CNT_W'((DAMP_CYCLES > 0) ? DAMP_CYCLES - 1 : 0);

  state_t             state;
  logic [3:0]         gates;
  logic               txrx_r, busy_r, done_r, err_r, aborted_r;
  logic [CNT_W-1:0]   h_r, d_r, phase_cnt;
  logic [BURST_W-1:0] n_r, burst_cnt;
  logic [CNT_W-1:0]   dead_last, drive_last;
  logic [BURST_W-1:0] burst_last;
  logic               cfg_bad;

  assign dead_last  = d_r - ONE_C;
  assign drive_last = h_r - d_r - ONE_C;
  assign burst_last = n_r - ONE_B;
  assign cfg_bad    = (bus.half_period == '0) || (bus.dead_time == '0) ||
                      (bus.dead_time >= bus.half_period) || (bus.n_cycles == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      gates     <= G_OFF;
      txrx_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      aborted_r <= 1'b0;
      h_r       <= '0;
      d_r       <= '0;
      n_r       <= '0;
      phase_cnt <= '0;
      burst_cnt <= '0;
    end else begin
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      aborted_r <= 1'b0;
      if (bus.abort && busy_r) begin
        // abort wins over everything, damping included
        state     <= IDLE;
        gates     <= G_OFF;
        txrx_r    <= 1'b0;
        busy_r    <= 1'b0;
        aborted_r <= 1'b1;
        phase_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              if (cfg_bad) begin
                err_r <= 1'b1;
              end else begin
                h_r       <= bus.half_period;
                d_r       <= bus.dead_time;
                n_r       <= bus.n_cycles;
                phase_cnt <= '0;
                burst_cnt <= '0;
                state     <= DEAD_A;
                gates     <= G_OFF;
                txrx_r    <= 1'b1;
                busy_r    <= 1'b1;
              end
            end
          end
          DEAD_A: begin
            if (phase_cnt == dead_last) begin
              phase_cnt <= '0;
              state     <= DRIVE_A;
              gates     <= G_A;
            end else begin
              phase_cnt <= phase_cnt + ONE_C;
            end
          end
          DRIVE_A: begin
            if (phase_cnt == drive_last) begin
              phase_cnt <= '0;
              state     <= DEAD_B;
              gates     <= G_OFF;
            end else begin
              phase_cnt <= phase_cnt + ONE_C;
            end
          end
          DEAD_B: begin
            if (phase_cnt == dead_last) begin
              phase_cnt <= '0;
              state     <= DRIVE_B;
              gates     <= G_B;
            end else begin
              phase_cnt <= phase_cnt + ONE_C;
            end
          end
          DRIVE_B: begin
            if (phase_cnt == drive_last) begin
              phase_cnt <= '0;
              gates     <= G_OFF;
              burst_cnt <= burst_cnt + ONE_B;
              // compare before increment so N = 2^BURST_W-1 never wraps
              if (burst_cnt != burst_last) begin
                state <= DEAD_A;
              end else if (DAMP_CYCLES > 0) begin
                state <= DEAD_C;
              end else begin
                state  <= DONE;
                txrx_r <= 1'b0;
                busy_r <= 1'b0;
                done_r <= 1'b1;
              end
            end else begin
              phase_cnt <= phase_cnt + ONE_C;
            end
          end
          DEAD_C: begin
            if (phase_cnt == dead_last) begin
              phase_cnt <= '0;
              state     <= DAMP;
              gates     <= G_DAMP;
            end else begin
              phase_cnt <= phase_cnt + ONE_C;
            end
          end
          DAMP: begin
            if (phase_cnt == DAMP_LAST) begin
              phase_cnt <= '0;
              state     <= DONE;
              gates     <= G_OFF;
              txrx_r    <= 1'b0;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
            end else begin
              phase_cnt <= phase_cnt + ONE_C;
            end
          end
          DONE: begin
            state <= IDLE;
            gates <= G_OFF;
          end
          default: begin
            state  <= IDLE;
            gates  <= G_OFF;
            txrx_r <= 1'b0;
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.hlh       = gates[3];
  assign bus.hll       = gates[2];
  assign bus.hrh       = gates[1];
  assign bus.hrl       = gates[0];
  assign bus.txrx      = txrx_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.aborted   = aborted_r;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_h_bridge_burst.sv
// Directed and random checks of h_bridge_burst: one instance without damping, one with a 3-cycle window.
module tb_h_bridge_burst;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // observed word {hlh,hll,hrh,hrl,txrx,busy,done,err,aborted}
  logic [8:0] exp_q[$];
  localparam logic [3:0] P_A = 4'b1001, P_B = 4'b0110, P_D = 4'b0101, P_0 = 4'b0000;
  localparam logic [8:0] W_IDLE = 9'b0000_00000;
  localparam logic [8:0] W_DONE = 9'b0000_00100;
  localparam logic [8:0] W_ERR  = 9'b0000_00010;
  localparam logic [8:0] W_ABT  = 9'b0000_00001;

  h_bridge_burst_if #(.CNT_W(16), .BURST_W(8)) if0 ();
  h_bridge_burst_if #(.CNT_W(16), .BURST_W(8)) if1 ();

  h_bridge_burst #(.CNT_W(16), .BURST_W(8), .DAMP_CYCLES(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  h_bridge_burst #(.CNT_W(16), .BURST_W(8), .DAMP_CYCLES(3)) u1 (.clk(clk), .rst(rst), .bus(if1));

  // clock / timeout
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic drive(input int sel, input bit st, input bit ab, input int h, input int d, input int n);
    if (sel == 0 || sel == 2) begin
      if0.start = st; if0.abort = ab;
      if0.half_period = 16'(h); if0.dead_time = 16'(d); if0.n_cycles = 8'(n);
    end else begin
      if0.start = 1'b0; if0.abort = 1'b0;
    end
    if (sel == 1 || sel == 2) begin
      if1.start = st; if1.abort = ab;
      if1.half_period = 16'(h); if1.dead_time = 16'(d); if1.n_cycles = 8'(n);
    end else begin
      if1.start = 1'b0; if1.abort = 1'b0;
    end
  endtask

  function automatic logic [8:0] get_out(input int sel);
    if (sel == 0)
      return {if0.hlh, if0.hll, if0.hrh, if0.hrl, if0.txrx, if0.busy, if0.done, if0.err, if0.aborted};
    return {if1.hlh, if1.hll, if1.hrh, if1.hrl, if1.txrx, if1.busy, if1.done, if1.err, if1.aborted};
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  // scoreboard-driven burst: expected per-cycle words are queued up front, popped one per cycle
  task automatic run_burst(input int sel, input int h, input int d, input int n, input int damp,
                           input int poke_at, input int abort_at, input string tag);
    int i;
    logic [8:0] e;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      repeat (d)     exp_q.push_back({P_0, 5'b11000});
      repeat (h - d) exp_q.push_back({P_A, 5'b11000});
      repeat (d)     exp_q.push_back({P_0, 5'b11000});
      repeat (h - d) exp_q.push_back({P_B, 5'b11000});
    end
    if (damp > 0) begin
      repeat (d)    exp_q.push_back({P_0, 5'b11000});
      repeat (damp) exp_q.push_back({P_D, 5'b11000});
    end
    exp_q.push_back(W_DONE);
    exp_q.push_back(W_IDLE);
    @(negedge clk); drive(sel, 1'b1, 1'b0, h, d, n);
    @(negedge clk); drive(sel, 1'b0, 1'b0, h, d, n);
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(tag, get_out(sel), e);
      if (poke_at >= 0 && i == poke_at) drive(sel, 1'b1, 1'b0, h + 5, d, n);
      else if (poke_at >= 0 && i == poke_at + 1) drive(sel, 1'b0, 1'b0, h + 5, d, n);
      if (abort_at >= 0 && i == abort_at) begin
        drive(sel, 1'b0, 1'b1, h, d, n);
        exp_q.delete();
        exp_q.push_back(W_ABT);
        exp_q.push_back(W_IDLE);
      end else if (abort_at >= 0 && i == abort_at + 1) begin
        drive(sel, 1'b0, 1'b0, h, d, n);
      end
      i++;
      @(negedge clk);
    end
  endtask

  task automatic reject(input int sel, input int h, input int d, input int n, input string tag);
    @(negedge clk); drive(sel, 1'b1, 1'b0, h, d, n);
    @(negedge clk); drive(sel, 1'b0, 1'b0, h, d, n);
    chk(tag, get_out(sel), W_ERR);
    @(negedge clk);
    chk(tag, get_out(sel), W_IDLE);
  endtask

  // invariant monitor: shoot-through and dead time between distinct non-zero patterns
  bit         mon_on = 1'b0;
  int         mon_d  = 1;
  logic [3:0] g[2];
  logic [3:0] last_nz[2] = '{4'b0, 4'b0};
  int         off_run[2] = '{0, 0};
  assign g[0] = {if0.hlh, if0.hll, if0.hrh, if0.hrl};
  assign g[1] = {if1.hlh, if1.hll, if1.hrh, if1.hrl};

  always @(negedge clk) begin
    if (mon_on) begin
      for (int u = 0; u < 2; u++) begin
        total++;
        assert (!(g[u][3] && g[u][2]) && !(g[u][1] && g[u][0])) else begin
          bad++;
          $error("FAIL shoot_through u%0d obs=%b exp=no_leg_pair", u, g[u]);
        end
        if (g[u] == 4'b0) begin
          off_run[u]++;
        end else begin
          if (last_nz[u] != 4'b0 && g[u] != last_nz[u]) begin
            total++;
            assert (off_run[u] >= mon_d) else begin
              bad++;
              $error("FAIL dead_time u%0d obs=%0d exp>=%0d", u, off_run[u], mon_d);
            end
          end
          last_nz[u] = g[u];
          off_run[u] = 0;
        end
      end
    end
  end

  // directed sequence
  initial begin
    int cur_d, h, n;
    bit st, ab;
    drive(2, 1'b0, 1'b0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset_u0", get_out(0), W_IDLE);
    chk("reset_u1", get_out(1), W_IDLE);
    rst = 1'b1;
    @(negedge clk);

    run_burst(0, 4, 1, 2, 0, -1, -1, "basic_n2");
    run_burst(1, 4, 1, 1, 3, -1, -1, "damp_n1");
    reject(0, 4, 4, 1, "rej_d_eq_h");
    reject(0, 4, 0, 1, "rej_d_zero");
    reject(0, 0, 1, 1, "rej_h_zero");
    reject(1, 4, 1, 0, "rej_n_zero");

    // abort held in IDLE drops a simultaneous start silently
    @(negedge clk); drive(0, 1'b1, 1'b1, 4, 1, 1);
    @(negedge clk); drive(0, 1'b0, 1'b0, 4, 1, 1);
    chk("abort_idle", get_out(0), W_IDLE);
    @(negedge clk);
    chk("abort_idle2", get_out(0), W_IDLE);

    run_burst(0, 8, 2, 4, 0, -1, 6, "abort_mid");
    run_burst(0, 4, 1, 1, 0, -1, -1, "after_abort");
    run_burst(1, 4, 1, 1, 3, -1, 9, "abort_damp");
    run_burst(0, 6, 2, 2, 0, 5, -1, "poke_ignored");
    run_burst(1, 5, 2, 2, 3, 12, -1, "poke_ignored_d");
    run_burst(0, 2, 1, 255, 0, -1, -1, "n_max");

    // reset in the middle of DRIVE_A
    @(negedge clk); drive(0, 1'b1, 1'b0, 4, 1, 2);
    @(negedge clk); drive(0, 1'b0, 1'b0, 4, 1, 2);
    chk("pre_rst_dead", get_out(0), {P_0, 5'b11000});
    @(negedge clk);
    chk("pre_rst_drive", get_out(0), {P_A, 5'b11000});
    rst = 1'b0;
    @(negedge clk);
    chk("rst_edge", get_out(0), W_IDLE);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_after", get_out(0), W_IDLE);
    run_burst(0, 4, 1, 1, 0, -1, -1, "after_rst");

    // random configs, starts and aborts with the invariant monitor watching both instances
    mon_on = 1'b1;
    for (int seg = 0; seg < 10; seg++) begin
      cur_d = $urandom_range(1, 4);
      mon_d = cur_d;
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk);
        h  = $urandom_range(0, 12);
        n  = $urandom_range(0, 3);
        st = ($urandom_range(0, 7) == 0);
        ab = ($urandom_range(0, 99) == 0);
        drive(2, st, ab, h, cur_d, n);
      end
      @(negedge clk); drive(2, 1'b0, 1'b1, 8, cur_d, 1);
      @(negedge clk); drive(2, 1'b0, 1'b0, 8, cur_d, 1);
      @(negedge clk);
    end
    mon_on = 1'b0;
    @(negedge clk);
    chk("rand_end_u0", get_out(0), W_IDLE);
    chk("rand_end_u1", get_out(1), W_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/h_bridge_burst.md
Name: h_bridge_burst

Overview:
- Parametrised successor to the fixed-state H-bridge driver.
- Generates a transducer ping: a programmable burst of N full-bridge cycles with a runtime-set half-period and dead-time, an optional low-side damping window, and a T/R switch (txrx) envelope.
- Sits between the DVL control logic (I2C register side) and the four bridge gate outputs.
- Replaces the static hstate selection.

Parameters:
- CNT_W, 16: width of half_period and dead_time counters.
- BURST_W, 8: width of n_cycles and the burst counter.
- DAMP_CYCLES, 32: length of the post-burst low-side damping window; 0 disables damping.

Ports:
- clk  in  1  system clock (HSOSC domain).
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  level; forces bridge off.
- half_period  in  CNT_W  H, clocks per half-cycle, including dead time.
- dead_time  in  CNT_W  D, all-off clocks at the start of each half.
- n_cycles  in  BURST_W  N, number of full cycles.
- hlh, hll, hrh, hrl  out  1 each  gate drives: left-high, left-low, right-high, right-low.
- txrx  out  1  T/R switch; 1 means transmit.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on a rejected start.
- aborted  out  1  one-cycle pulse when an abort terminates a burst.

Behaviour:
- All outputs are registered.
- While rst=0 at a clk edge: state=IDLE; all gates, txrx, busy, done, err, aborted = 0; counters cleared.
- Reset mid-burst takes effect on that edge: all outputs go low, with no done/aborted pulse.
- Configuration is latched on an accepted start and held for the whole burst. Input changes during a burst are ignored.
- Start acceptance in IDLE:
  - Rejected if H==0, D==0, D>=H, or N==0. On rejection: err=1 next cycle, state stays IDLE, gates stay off.
  - Start while busy is ignored, with no err.
- States:
  - IDLE: gates off.
  - DEAD_A: D cycles, gates off.
  - DRIVE_A: H-D cycles, hlh=1, hrl=1.
  - DEAD_B: D cycles, off.
  - DRIVE_B: H-D cycles, hrh=1, hll=1.
  - After DRIVE_B, the burst counter increments. If count<N, go to DEAD_A. Otherwise go to DEAD_C if DAMP_CYCLES>0, else go to DONE.
  - DEAD_C: D cycles, off.
  - DAMP: DAMP_CYCLES cycles, hll=1, hrl=1.
  - DONE: 1 cycle, gates off, done=1, busy=0, txrx=0; then IDLE.
- Timing:
  - An accepted start at edge 0 puts the FSM in DEAD_A at edge 1. busy and txrx are 1 from edge 1.
  - txrx and busy stay high through the last DAMP cycle, or through the last DRIVE_B cycle when damping is disabled.
  - busy duration = 2·N·H + (DAMP_CYCLES>0 ? D + DAMP_CYCLES : 0) cycles. done follows on the next cycle.
- Safety invariants, which hold in every cycle including abort and reset:
  - Never hlh&hll, and never hrh&hrl.
  - Every change between two distinct non-zero gate patterns passes through at least D consecutive all-off cycles.
- Abort:
  - abort=1 while busy: on the next edge all gates=0, txrx=0, busy=0, aborted=1 for one cycle, then IDLE. Damping is skipped.
  - abort=1 in IDLE blocks acceptance of start; a simultaneous start is dropped with no err.
  - Abort has priority over start and over normal state progression.
- Counters:
  - Phase counter counts 0..len-1, then advances state.
  - The burst counter is BURST_W bits wide. N=2^BURST_W-1 must complete without wrap; the comparison is done before increment.

Test Plan:
- H=4, D=1, N=2, DAMP_CYCLES=0, start pulse:
  - Gate pattern over 16 cycles: per half-cycle 1 off + 3 A, then 1 off + 3 B, repeated twice.
  - busy=16 cycles, then done for 1 cycle; txrx matches busy.
- H=4, D=1, N=1, DAMP_CYCLES=3:
  - After the last DRIVE_B, 1 off cycle, then 3 cycles hll=hrl=1.
  - busy=12 cycles, then done.
- Rejection, one start each for (H=4,D=4,N=1), (H=4,D=0,N=1), (H=0,D=1,N=1), (H=4,D=1,N=0):
  - err pulse each time; gates and busy stay 0.
- Abort asserted at cycle 6 of an H=8, D=2, N=4 burst:
  - Next edge: gates=0, txrx=0, aborted=1 for 1 cycle, no done.
  - A following start is accepted normally.
- Start re-pulsed and half_period changed mid-burst:
  - No effect; the burst completes with the originally latched H.
- rst=0 for 1 cycle mid-DRIVE_A, then random configs/aborts for 10k cycles with an assertion monitor:
  - All outputs 0 on the reset edge.
  - Shoot-through invariant and ≥D dead-time invariant never violated.
